// File: rtl/multi_mod_counter.sv
// Cascaded modulo-MOD_VALUE up/down counter with parallel load and terminal-count flags.
// Define MULTI_MOD_COUNTER_TC_REG_EN to register rolling_over, rolling_under and stage_carry.
module multi_mod_counter #(
    parameter int MOD_VALUE = 10,
    parameter int WID       = 4,
    parameter int STAGES    = 2,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    increment,
    input  logic                    decrement,
    input  logic                    load,
    input  logic [STAGES*WID-1:0]   load_value,
    output logic [STAGES*WID-1:0]   count,
    output logic                    rolling_over,
    output logic                    rolling_under,
    output logic [STAGES-1:0]       stage_carry
);

    localparam logic [WID-1:0] MAX_VAL = WID'(MOD_VALUE - 1);
    localparam logic [WID:0]   MOD_EXT = (WID + 1)'(MOD_VALUE);

    logic [STAGES*WID-1:0] count_q;
    logic [STAGES*WID-1:0] count_d;
    logic [STAGES*WID-1:0] load_clamped;
    logic [STAGES*WID-1:0] stage_up;
    logic [STAGES*WID-1:0] stage_down;
    logic [STAGES-1:0]     at_max;
    logic [STAGES-1:0]     at_zero;
    logic [STAGES:0]       max_prefix;
    logic [STAGES:0]       zero_prefix;
    logic                  up_step;
    logic                  down_step;
    logic                  step_ok;
    logic                  rolling_over_d;
    logic                  rolling_under_d;
    logic [STAGES-1:0]     stage_carry_d;

    assign up_step   = increment & ~decrement;
    assign down_step = decrement & ~increment;
    assign step_ok   = ~reset & ~load;

    // Per-stage helpers: limit detection, wrapped neighbours and clamped load data.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WID-1:0] cur;
        logic [WID-1:0] lv;

        assign cur = count_q[k*WID +: WID];
        assign lv  = load_value[k*WID +: WID];

        assign at_max[k]  = (cur == MAX_VAL);
        assign at_zero[k] = (cur == '0);

        assign stage_up[k*WID +: WID]     = (cur == MAX_VAL) ? '0 : cur + 1'b1;
        assign stage_down[k*WID +: WID]   = (cur == '0) ? MAX_VAL : cur - 1'b1;
        assign load_clamped[k*WID +: WID] = ({1'b0, lv} >= MOD_EXT) ? MAX_VAL : lv;
    end

    // Bit k of each prefix says every stage below k sits at its limit.
    always_comb begin
        max_prefix     = '0;
        zero_prefix    = '0;
        max_prefix[0]  = 1'b1;
        zero_prefix[0] = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            max_prefix[k+1]  = max_prefix[k] & at_max[k];
            zero_prefix[k+1] = zero_prefix[k] & at_zero[k];
        end
    end

    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (up_step && !(SATURATE && max_prefix[STAGES])) begin
            for (int k = 0; k < STAGES; k++) begin
                if (max_prefix[k]) begin
                    count_d[k*WID +: WID] = stage_up[k*WID +: WID];
                end
            end
        end else if (down_step && !(SATURATE && zero_prefix[STAGES])) begin
            for (int k = 0; k < STAGES; k++) begin
                if (zero_prefix[k]) begin
                    count_d[k*WID +: WID] = stage_down[k*WID +: WID];
                end
            end
        end
    end

    // A stage carries when it and every stage below it sit at the limit in the step direction.
    always_comb begin
        stage_carry_d   = '0;
        rolling_over_d  = step_ok & up_step & max_prefix[STAGES];
        rolling_under_d = step_ok & down_step & zero_prefix[STAGES];
        for (int k = 0; k < STAGES; k++) begin
            stage_carry_d[k] = step_ok & ((up_step & max_prefix[k+1]) |
                                          (down_step & zero_prefix[k+1]));
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

`ifdef MULTI_MOD_COUNTER_TC_REG_EN
    logic              rolling_over_q;
    logic              rolling_under_q;
    logic [STAGES-1:0] stage_carry_q;

    // The _d terms are already forced low under reset, so these flops clear with it.
    always_ff @(posedge clk) begin
        rolling_over_q  <= rolling_over_d;
        rolling_under_q <= rolling_under_d;
        stage_carry_q   <= stage_carry_d;
    end

    assign rolling_over  = rolling_over_q;
    assign rolling_under = rolling_under_q;
    assign stage_carry   = stage_carry_q;
`else
    assign rolling_over  = rolling_over_d;
    assign rolling_under = rolling_under_d;
    assign stage_carry   = stage_carry_d;
`endif

endmodule

// File: tb/tb_multi_mod_counter.sv
// Self-checking bench for multi_mod_counter: directed scenarios plus randomized cycles
// against an integer-valued model, with a wrapping and a saturating instance side by side.
module tb_multi_mod_counter;

    localparam int MOD   = 10;
    localparam int WID   = 4;
    localparam int ST    = 2;
    localparam int W     = ST * WID;
    localparam int TOTAL = 100;
`ifdef MULTI_MOD_COUNTER_TC_REG_EN
    localparam bit TC_REG = 1'b1;
`else
    localparam bit TC_REG = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          increment;
    logic          decrement;
    logic          load;
    logic [W-1:0]  load_value;
    logic [W-1:0]  count_w;
    logic [W-1:0]  count_s;
    logic          rolling_over_w;
    logic          rolling_under_w;
    logic [ST-1:0] stage_carry_w;
    logic          rolling_over_s;
    logic          rolling_under_s;
    logic [ST-1:0] stage_carry_s;

    int checks = 0;
    int errors = 0;

    // Model state: each counter is a single integer in 0..TOTAL-1.
    int v_w = 0;
    int v_s = 0;

    logic [W-1:0]  exp_cnt_w, exp_cnt_s, obs_cnt_w, obs_cnt_s;
    logic [ST+1:0] exp_flags_w, exp_flags_s, obs_flags_w, obs_flags_s;

    multi_mod_counter #(.MOD_VALUE(MOD), .WID(WID), .STAGES(ST), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .load(load), .load_value(load_value), .count(count_w),
        .rolling_over(rolling_over_w), .rolling_under(rolling_under_w),
        .stage_carry(stage_carry_w)
    );

    multi_mod_counter #(.MOD_VALUE(MOD), .WID(WID), .STAGES(ST), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .load(load), .load_value(load_value), .count(count_s),
        .rolling_over(rolling_over_s), .rolling_under(rolling_under_s),
        .stage_carry(stage_carry_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pw(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * MOD;
        return r;
    endfunction

    function automatic int clamp_val(input logic [W-1:0] lv);
        int r = 0;
        for (int k = 0; k < ST; k++) begin
            int f = int'(lv[k*WID +: WID]);
            if (f > MOD - 1) f = MOD - 1;
            r = r + f * pw(k);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_packed(input int v);
        logic [W-1:0] p = '0;
        for (int k = 0; k < ST; k++) p[k*WID +: WID] = WID'((v / pw(k)) % MOD);
        return p;
    endfunction

    // Flags packed as {rolling_over, rolling_under, stage_carry}.
    function automatic logic [ST+1:0] model_flags(input int v, input logic rst,
            input logic inc, input logic dec, input logic ld);
        logic [ST+1:0] f = '0;
        logic up = inc && !dec && !ld && !rst;
        logic dn = dec && !inc && !ld && !rst;
        f[ST+1] = up && (v == TOTAL - 1);
        f[ST]   = dn && (v == 0);
        for (int k = 0; k < ST; k++)
            f[k] = (up && (v % pw(k+1)) == pw(k+1) - 1) || (dn && (v % pw(k+1)) == 0);
        return f;
    endfunction

    function automatic int model_next(input int v, input logic rst, input logic inc,
            input logic dec, input logic ld, input logic [W-1:0] lv, input bit sat);
        if (rst) return 0;
        if (ld) return clamp_val(lv);
        if (inc && !dec) return (v == TOTAL - 1) ? (sat ? v : 0) : v + 1;
        if (dec && !inc) return (v == 0) ? (sat ? v : TOTAL - 1) : v - 1;
        return v;
    endfunction

    // One clock of stimulus: flags are sampled at the falling edge (combinational build)
    // or just after the rising edge (registered build); count just after the rising edge.
    task automatic drive_cycle(input logic rst, input logic inc, input logic dec,
            input logic ld, input logic [W-1:0] lv);
        logic [ST+1:0] comb_w, comb_s;
        reset = rst; increment = inc; decrement = dec; load = ld; load_value = lv;
        exp_flags_w = model_flags(v_w, rst, inc, dec, ld);
        exp_flags_s = model_flags(v_s, rst, inc, dec, ld);
        @(negedge clk);
        comb_w = {rolling_over_w, rolling_under_w, stage_carry_w};
        comb_s = {rolling_over_s, rolling_under_s, stage_carry_s};
        @(posedge clk);
        #1;
        v_w = model_next(v_w, rst, inc, dec, ld, lv, 1'b0);
        v_s = model_next(v_s, rst, inc, dec, ld, lv, 1'b1);
        exp_cnt_w = to_packed(v_w);
        exp_cnt_s = to_packed(v_s);
        obs_cnt_w = count_w;
        obs_cnt_s = count_s;
        obs_flags_w = TC_REG ? {rolling_over_w, rolling_under_w, stage_carry_w} : comb_w;
        obs_flags_s = TC_REG ? {rolling_over_s, rolling_under_s, stage_carry_s} : comb_s;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        checks++;
        if (obs_cnt_w !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_count got %h expected 00", obs_cnt_w);
        end
        checks++;
        if (obs_cnt_s !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_count_sat got %h expected 00", obs_cnt_s);
        end
        checks++;
        if (obs_flags_w !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags got %b expected 0000", obs_flags_w);
        end
    endtask

    task automatic test_rollover();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        checks++;
        if (obs_cnt_w !== 8'h99) begin
            errors++; $display("[TB] FAIL load99_count got %h expected 99", obs_cnt_w);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_flags_w !== 4'b1011) begin
            errors++; $display("[TB] FAIL rollover_flags got %b expected 1011", obs_flags_w);
        end
        checks++;
        if (obs_cnt_w !== 8'h00) begin
            errors++; $display("[TB] FAIL rollover_count got %h expected 00", obs_cnt_w);
        end
    endtask

    task automatic test_rollunder();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (obs_flags_w !== 4'b0111) begin
            errors++; $display("[TB] FAIL rollunder_flags got %b expected 0111", obs_flags_w);
        end
        checks++;
        if (obs_cnt_w !== 8'h99) begin
            errors++; $display("[TB] FAIL rollunder_count got %h expected 99", obs_cnt_w);
        end
    endtask

    task automatic test_partial_carry();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_flags_w !== 4'b0001) begin
            errors++; $display("[TB] FAIL carry09_flags got %b expected 0001", obs_flags_w);
        end
        checks++;
        if (obs_cnt_w !== 8'h10) begin
            errors++; $display("[TB] FAIL carry09_count got %h expected 10", obs_cnt_w);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (obs_flags_w !== 4'b0001 || obs_cnt_w !== 8'h09) begin
            errors++;
            $display("[TB] FAIL borrow10 got flags %b count %h expected 0001 09", obs_flags_w, obs_cnt_w);
        end
    endtask

    task automatic test_inc_dec_together();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h19);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checks++;
        if (obs_cnt_w !== 8'h19) begin
            errors++; $display("[TB] FAIL incdec_count got %h expected 19", obs_cnt_w);
        end
        checks++;
        if (obs_flags_w !== 4'b0000) begin
            errors++; $display("[TB] FAIL incdec_flags got %b expected 0000", obs_flags_w);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        checks++;
        if (obs_cnt_w !== 8'h19) begin
            errors++; $display("[TB] FAIL idle_hold got %h expected 19", obs_cnt_w);
        end
    endtask

    task automatic test_load();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hF3);
        checks++;
        if (obs_cnt_w !== 8'h93) begin
            errors++; $display("[TB] FAIL load_clamp got %h expected 93", obs_cnt_w);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h25);
        checks++;
        if (obs_cnt_w !== 8'h25) begin
            errors++; $display("[TB] FAIL load_wins got %h expected 25", obs_cnt_w);
        end
        checks++;
        if (obs_flags_w !== 4'b0000) begin
            errors++; $display("[TB] FAIL load_flags got %b expected 0000", obs_flags_w);
        end
    endtask

    task automatic test_saturate();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_cnt_s !== 8'h99) begin
                errors++; $display("[TB] FAIL sat_hi_count[%0d] got %h expected 99", i, obs_cnt_s);
            end
            checks++;
            if (obs_flags_s !== 4'b1011) begin
                errors++; $display("[TB] FAIL sat_hi_flags[%0d] got %b expected 1011", i, obs_flags_s);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (obs_cnt_s !== 8'h00 || obs_flags_s !== 4'b0111) begin
                errors++;
                $display("[TB] FAIL sat_lo[%0d] got count %h flags %b expected 00 0111", i, obs_cnt_s, obs_flags_s);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_cnt_w !== 8'h00 || obs_flags_w !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL b2b_wrap got count %h flags %b expected 00 1011", obs_cnt_w, obs_flags_w);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (obs_cnt_w !== 8'h00 || obs_flags_w !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL b2b_reset got count %h flags %b expected 00 0000", obs_cnt_w, obs_flags_w);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            logic [W-1:0] lv;
            case ($urandom_range(0, 3))
                0:       lv = 8'h99;
                1:       lv = 8'h00;
                default: lv = 8'($urandom);
            endcase
            drive_cycle(r < 3, 1'($urandom), 1'($urandom), r < 12, lv);
            checks++;
            if (obs_cnt_w !== exp_cnt_w) begin
                errors++; $display("[TB] FAIL rnd_count[%0d] got %h expected %h", n, obs_cnt_w, exp_cnt_w);
            end
            checks++;
            if (obs_cnt_s !== exp_cnt_s) begin
                errors++; $display("[TB] FAIL rnd_count_sat[%0d] got %h expected %h", n, obs_cnt_s, exp_cnt_s);
            end
            checks++;
            if (obs_flags_w !== exp_flags_w) begin
                errors++; $display("[TB] FAIL rnd_flags[%0d] got %b expected %b", n, obs_flags_w, exp_flags_w);
            end
            checks++;
            if (obs_flags_s !== exp_flags_s) begin
                errors++; $display("[TB] FAIL rnd_flags_sat[%0d] got %b expected %b", n, obs_flags_s, exp_flags_s);
            end
        end
    endtask

    initial begin
        reset = 1'b0; increment = 1'b0; decrement = 1'b0; load = 1'b0; load_value = '0;
        test_reset();
        test_rollover();
        test_rollunder();
        test_partial_carry();
        test_inc_dec_together();
        test_load();
        test_saturate();
        test_back_to_back();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
